// File: rtl/fp_conv_pkg.sv
// Shared constants and types for the fp32 <-> fp16 conversion stages.
//   - Field widths and exponent biases of both IEEE-754 formats.
//   - Canonical fp16 special encodings (quiet NaN, infinity).
//   - FSM state type used by the streaming narrowing converter.
package fp_conv_pkg;

  localparam int unsigned FP32_EXP_W   = 8;
  localparam int unsigned FP32_MAN_W   = 23;
  localparam int unsigned FP16_EXP_W   = 5;
  localparam int unsigned FP16_MAN_W   = 10;

  localparam int unsigned FP32_BIAS    = 127;
  localparam int unsigned FP16_BIAS    = 15;
  localparam int unsigned BIAS_DIFF    = 112;

  // Largest biased fp16 exponent; reserved for infinity/NaN.
  localparam int unsigned FP16_EXP_MAX = 31;

  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_INF     = 16'h7C00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } conv_state_t;

  // Assemble an fp16 word from its fields.
  function automatic logic [15:0] fp16_pack(input logic       sign,
                                            input logic [4:0] exp,
                                            input logic [9:0] man);
    return {sign, exp, man};
  endfunction

endpackage

// File: rtl/fp32_to_fp16_lane.sv
// Single-word fp32 -> fp16 converter, purely combinational.
//   Rounding: round-to-nearest-even on the 13 discarded mantissa bits.
//   Overflow (before or after rounding) saturates to signed infinity.
//   Results below the normal fp16 range flush to signed zero.
//   NaN inputs become the canonical quiet NaN with the input sign.
// Ports:
//   i_fp32  in  32  IEEE-754 single-precision word
//   o_fp16  out 16  IEEE-754 half-precision word
module fp32_to_fp16_lane
  import fp_conv_pkg::*;
(
  input  logic [31:0] i_fp32,
  output logic [15:0] o_fp16
);

  localparam int unsigned DROP_W = FP32_MAN_W - FP16_MAN_W;

  logic                  w_sign;
  logic [FP32_EXP_W-1:0] w_exp;
  logic [FP32_MAN_W-1:0] w_man;
  logic signed [8:0]     w_re;
  logic [FP16_MAN_W-1:0] w_km;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_round_up;
  logic [FP16_MAN_W:0]   w_man_rnd;
  logic [FP16_EXP_W-1:0] w_exp_rnd;

  assign w_sign = i_fp32[31];
  assign w_exp  = i_fp32[30:23];
  assign w_man  = i_fp32[22:0];

  // Rebiased exponent; only meaningful for normal fp32 inputs.
  assign w_re = $signed({1'b0, w_exp}) - $signed(9'(BIAS_DIFF));

  assign w_km       = w_man[FP32_MAN_W-1 -: FP16_MAN_W];
  assign w_guard    = w_man[DROP_W-1];
  assign w_sticky   = |w_man[DROP_W-2:0];
  assign w_round_up = w_guard & (w_sticky | w_km[0]);

  assign w_man_rnd  = {1'b0, w_km} + (FP16_MAN_W+1)'(w_round_up);

  // A mantissa carry leaves the fraction at zero and bumps the exponent;
  // from re == 30 that lands on 31 with zero fraction, i.e. infinity.
  assign w_exp_rnd  = w_re[FP16_EXP_W-1:0] + FP16_EXP_W'(w_man_rnd[FP16_MAN_W]);

  always_comb begin
    o_fp16 = '0;
    if (w_exp == '1) begin
      if (w_man != '0) begin
        o_fp16 = {w_sign, FP16_QNAN[14:0]};
      end else begin
        o_fp16 = {w_sign, FP16_INF[14:0]};
      end
    end else if (w_exp == '0) begin
      o_fp16 = {w_sign, 15'd0};
    end else if (w_re <= 9'sd0) begin
      o_fp16 = {w_sign, 15'd0};
    end else if (w_re >= $signed(9'(FP16_EXP_MAX))) begin
      o_fp16 = {w_sign, FP16_INF[14:0]};
    end else begin
      o_fp16 = fp16_pack(w_sign, w_exp_rnd, w_man_rnd[FP16_MAN_W-1:0]);
    end
  end

endmodule

// File: rtl/convert_32to16_stream.sv
// Streaming fp32 -> fp16 vector narrowing stage.
//   On start (in IDLE) the fp32 input vector is snapshotted; then LANES
//   words per clock are converted and written into the registered fp16
//   output vector. done pulses for one cycle after the last chunk.
// Ports:
//   clk        in  1                    rising-edge clock
//   reset      in  1                    asynchronous, active-high reset
//   start      in  1                    conversion request, honoured in IDLE
//   input_fc   in  DATA_WIDTH_2*NODES   fp32 vector, word i at [32*i +: 32]
//   output_fc  out DATA_WIDTH_1*NODES   fp16 vector, word i at [16*i +: 16]
//   busy       out 1                    high while chunks are written
//   done       out 1                    one-cycle completion pulse
module convert_32to16_stream
  import fp_conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_1 = 16,
  parameter int unsigned DATA_WIDTH_2 = 32,
  parameter int unsigned NODES        = 400,
  parameter int unsigned LANES        = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DATA_WIDTH_2*NODES-1:0]  input_fc,
  output logic [DATA_WIDTH_1*NODES-1:0]  output_fc,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned CHUNKS = NODES / LANES;
  localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  if ((NODES % LANES) != 0) begin : g_bad_nodes
    $error("NODES must be a multiple of LANES");
  end
  if ((DATA_WIDTH_1 != 16) || (DATA_WIDTH_2 != 32)) begin : g_bad_width
    $error("Lane converter supports only fp32 -> fp16");
  end

  conv_state_t                   r_state;
  conv_state_t                   w_next;
  logic [CW-1:0]                 r_cnt;
  logic [DATA_WIDTH_2*NODES-1:0] r_snap;
  logic                          w_last;
  logic [31:0]                   w_base;
  logic [DATA_WIDTH_2-1:0]       w_lane_in  [LANES];
  logic [DATA_WIDTH_1-1:0]       w_lane_out [LANES];

  assign w_last = (r_cnt == CW'(CHUNKS - 1));
  assign w_base = 32'(r_cnt) * LANES;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE:             w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  // Select the current chunk of the snapshot for the lane converters.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_lane_in[l] = r_snap[(w_base + l)*DATA_WIDTH_2 +: DATA_WIDTH_2];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp32_to_fp16_lane u_lane (
      .i_fp32 (w_lane_in[g]),
      .o_fp16 (w_lane_out[g])
    );
  end

  // Datapath: snapshot, chunk counter, output vector and status flags.
  // busy/done are registered so they line up with the chunk writes:
  // busy rises with the first chunk write and falls as done pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap    <= '0;
      r_cnt     <= '0;
      output_fc <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            r_snap <= input_fc;
            r_cnt  <= '0;
          end
        end
        ST_RUN: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            output_fc[(w_base + l)*DATA_WIDTH_1 +: DATA_WIDTH_1] <= w_lane_out[l];
          end
          busy  <= 1'b1;
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
        ST_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_convert_32to16_stream.sv
module tb_convert_32to16_stream;

  localparam int unsigned DW1    = 16;
  localparam int unsigned DW2    = 32;
  localparam int unsigned NODES  = 400;
  localparam int unsigned LANES  = 8;
  localparam int unsigned CHUNKS = NODES / LANES;
  localparam int unsigned NVEC   = 17;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic [DW2*NODES-1:0]  input_fc;
  logic [DW1*NODES-1:0]  output_fc;
  logic                  busy;
  logic                  done;

  int n_checks;
  int n_errors;

  logic [15:0] exp_old [NODES];
  logic [15:0] exp_new [NODES];

  // Directed vectors: fp32 input and hand-computed fp16 result.
  logic [31:0] vec_in  [NVEC];
  logic [15:0] vec_out [NVEC];

  convert_32to16_stream #(
    .DATA_WIDTH_1 (DW1),
    .DATA_WIDTH_2 (DW2),
    .NODES        (NODES),
    .LANES        (LANES)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .input_fc  (input_fc),
    .output_fc (output_fc),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] int_to_fp32(input int unsigned v);
    int p;
    if (v == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 32; b++) if (v[b]) p = b;
    return {1'b0, 8'(127 + p), 23'((v << (23 - p)) & 32'h007F_FFFF)};
  endfunction

  function automatic logic [15:0] int_to_fp16(input int unsigned v);
    int p;
    if (v == 0) return 16'h0;
    p = 0;
    for (int b = 0; b < 32; b++) if (v[b]) p = b;
    return {1'b0, 5'(15 + p), 10'((v << (10 - p)) & 32'h3FF)};
  endfunction

  function automatic logic [15:0] out_word(input int unsigned i);
    return output_fc[i*DW1 +: DW1];
  endfunction

  // Pulse start at the current negedge and follow the run cycle by cycle.
  // Sample n is taken after edge t+n, where t is the edge that samples start.
  task automatic run_vec(input bit interfere);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_n0", {31'd0, busy}, 32'd0);
    chk("done_n0", {31'd0, done}, 32'd0);
    for (int n = 1; n <= int'(CHUNKS) + 6; n++) begin
      if (interfere && n == 10) begin
        start    = 1'b1;
        input_fc = ~input_fc;
      end
      if (interfere && n == 11) start = 1'b0;
      if (interfere && n == int'(CHUNKS) + 1) start = 1'b1;
      if (interfere && n == int'(CHUNKS) + 2) start = 1'b0;
      @(negedge clk);
      chk($sformatf("busy_n%0d", n), {31'd0, busy}, {31'd0, (n <= int'(CHUNKS))});
      chk($sformatf("done_n%0d", n), {31'd0, done}, {31'd0, (n == int'(CHUNKS) + 1)});
      if (n <= int'(CHUNKS)) begin
        for (int l = 0; l < int'(LANES); l++) begin
          int w;
          w = (n - 1) * int'(LANES) + l;
          chk($sformatf("chunk_new_w%0d", w), {16'd0, out_word(w)}, {16'd0, exp_new[w]});
        end
      end
      if (n < int'(CHUNKS)) begin
        chk($sformatf("chunk_old_w%0d", n * int'(LANES)),
            {16'd0, out_word(n * LANES)}, {16'd0, exp_old[n * LANES]});
      end
    end
    for (int i = 0; i < int'(NODES); i++) begin
      chk($sformatf("final_w%0d", i), {16'd0, out_word(i)}, {16'd0, exp_new[i]});
      exp_old[i] = exp_new[i];
    end
  endtask

  task automatic load_ramp(input bit reversed);
    for (int i = 0; i < int'(NODES); i++) begin
      int unsigned v;
      v = reversed ? (NODES - 1 - i) : i;
      input_fc[i*DW2 +: DW2] = int_to_fp32(v);
      exp_new[i]             = int_to_fp16(v);
    end
  endtask

  initial begin
    bit done_seen;
    n_checks = 0;
    n_errors = 0;

    vec_in[0]  = 32'h3F80_0000; vec_out[0]  = 16'h3C00;
    vec_in[1]  = 32'hC040_0000; vec_out[1]  = 16'hC200;
    vec_in[2]  = 32'h477F_E000; vec_out[2]  = 16'h7BFF;
    vec_in[3]  = 32'h3F80_1000; vec_out[3]  = 16'h3C00;
    vec_in[4]  = 32'h3F80_3000; vec_out[4]  = 16'h3C02;
    vec_in[5]  = 32'h3F80_1001; vec_out[5]  = 16'h3C01;
    vec_in[6]  = 32'h477F_F000; vec_out[6]  = 16'h7C00;
    vec_in[7]  = 32'h7FC0_0001; vec_out[7]  = 16'h7E00;
    vec_in[8]  = 32'hFF80_0000; vec_out[8]  = 16'hFC00;
    vec_in[9]  = 32'h3727_C5AC; vec_out[9]  = 16'h0000;
    vec_in[10] = 32'hB727_C5AC; vec_out[10] = 16'h8000;
    vec_in[11] = 32'h0000_0001; vec_out[11] = 16'h0000;
    vec_in[12] = 32'h3880_0000; vec_out[12] = 16'h0400;
    vec_in[13] = 32'h7F80_0000; vec_out[13] = 16'h7C00;
    vec_in[14] = 32'h8000_0000; vec_out[14] = 16'h8000;
    vec_in[15] = 32'h4780_0000; vec_out[15] = 16'h7C00;
    vec_in[16] = 32'h387F_E000; vec_out[16] = 16'h0000;

    reset    = 1'b1;
    start    = 1'b0;
    input_fc = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_zero", {31'd0, |output_fc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed special/rounding vectors in the first words, zero elsewhere.
    for (int i = 0; i < int'(NODES); i++) begin
      exp_old[i] = 16'h0000;
      exp_new[i] = 16'h0000;
    end
    for (int i = 0; i < int'(NVEC); i++) begin
      input_fc[i*DW2 +: DW2] = vec_in[i];
      exp_new[i]             = vec_out[i];
    end
    run_vec(1'b0);

    // Full ramp; every word distinct from its predecessor run.
    load_ramp(1'b0);
    run_vec(1'b0);

    // Reversed ramp with a second start during busy and during DONE,
    // and input_fc scrambled mid-run.
    load_ramp(1'b1);
    run_vec(1'b1);

    // Reset in the middle of a run.
    load_ramp(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_zero", {31'd0, |output_fc}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    chk("midrst_no_activity", {31'd0, done_seen}, 32'd0);
    chk("midrst_out_held_zero", {31'd0, |output_fc}, 32'd0);

    // Fresh run after reset.
    for (int i = 0; i < int'(NODES); i++) exp_old[i] = 16'h0000;
    load_ramp(1'b0);
    run_vec(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
